// File: rtl/add_sub_serial_if.sv
// Start/done handshake and result bundle for the digit-serial adder/subtractor.
interface add_sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic             opcode;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             flag_out;
    logic             ovf_out;

    modport master (
        output start_in, opcode, a_in, b_in,
        input  busy_out, done_out, sum_out, flag_out, ovf_out
    );

    modport slave (
        input  start_in, opcode, a_in, b_in,
        output busy_out, done_out, sum_out, flag_out, ovf_out
    );
endinterface

// File: rtl/add_sub_serial.sv
// Digit-serial add/subtract, DIGIT bits per clock, LSB first, start/done handshake.
// Optional feature: define ADD_SUB_SAT_EN to saturate sum_out on signed overflow.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    add_sub_serial_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("add_sub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q, done_q, flag_q, ovf_q;
    logic [WIDTH-1:0] sum_q;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry, sign_a, sign_b;

    logic             accept;
    logic [DIGIT:0]   digit_sum;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0] res_next, sum_fin;
    logic             ovf_next;

`ifdef ADD_SUB_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s,
                                                  input logic ovf, input logic sa);
        logic signed [WIDTH-1:0] pos_max;
        logic signed [WIDTH-1:0] neg_min;
        pos_max = {1'b0, {(WIDTH-1){1'b1}}};
        neg_min = {1'b1, {(WIDTH-1){1'b0}}};
        if (ovf) return sa ? neg_min : pos_max;
        return s;
    endfunction
`endif

    assign accept = (state == IDLE) && bus.start_in;

    // New digit enters the result register from the MSB side, so after N
    // shifts the register holds the complete LSB-first sum.
    always_comb begin
        digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry};
        res_cat   = {digit_sum[DIGIT-1:0], res_sr};
        res_next  = res_cat[WIDTH+DIGIT-1:DIGIT];
        ovf_next  = (sign_a == sign_b) && (res_next[WIDTH-1] != sign_a);
    end

`ifdef ADD_SUB_SAT_EN
    assign sum_fin = saturate(res_next, ovf_next, sign_a);
`else
    assign sum_fin = res_next;
`endif

    // Operand shift registers and running carry need no reset: every bit is
    // loaded on accept before it is consumed.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            a_sr   <= bus.a_in;
            b_sr   <= bus.opcode ? ~bus.b_in : bus.b_in;
            carry  <= bus.opcode;
            sign_a <= bus.a_in[WIDTH-1];
            sign_b <= bus.opcode ? ~bus.b_in[WIDTH-1] : bus.b_in[WIDTH-1];
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_next;
            carry  <= digit_sum[DIGIT];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            flag_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cnt    <= '0;
                        sum_q  <= sum_fin;
                        flag_q <= digit_sum[DIGIT];
                        ovf_q  <= ovf_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;
    assign bus.sum_out  = sum_q;
    assign bus.flag_out = flag_q;
    assign bus.ovf_out  = ovf_q;
endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised digit-serial adder/subtractor for two's-complement and unsigned operands of WIDTH bits. It processes DIGIT bits per clock, LSB first, and trades latency for area. A single-cycle start/done handshake connects it to the datapath controllers. Outputs are the registered result, the carry/not-borrow flag and the signed overflow flag, all held stable until the next completed operation.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails.
- clk_in  input  1  clock; rising edge active.
- rst_n_in  input  1  reset; asynchronous, active-low.
- start_in  input  1  request; sampled only when idle.
- opcode  input  1  operation select: 0 = a+b, 1 = a−b. Sampled with start_in.
- a_in  input  WIDTH  operand A; sampled with start_in.
- b_in  input  WIDTH  operand B; sampled with start_in.
- busy_out  output  1  operation in progress.
- done_out  output  1  one-cycle completion pulse.
- sum_out  output  WIDTH  result.
- flag_out  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf_out  output  1  signed overflow.

## Operation
- N = WIDTH/DIGIT digit cycles per operation.
- FSM states:
  - IDLE → RUN when start_in = 1.
  - RUN → IDLE after digit N−1, issuing the done_out pulse.
- On accept:
  - latch A and B' = opcode ? ~b_in : b_in;
  - initialise carry to opcode;
  - set digit counter to 0;
  - store sign bits a_in[WIDTH−1] and B'[WIDTH−1].
- Each RUN cycle:
  - {c, s} = A[DIGIT−1:0] + B'[DIGIT−1:0] + c;
  - shift A and B' right by DIGIT;
  - shift s into the result register from the MSB side;
  - increment the counter.
- Completion:
  - flag_out = final carry.
  - ovf_out = (signA == signB') && (sum MSB != signA).
  - All arithmetic is modulo 2^WIDTH. No sign extension is applied.
- start_in while busy is ignored. Operand changes while busy have no effect.
- sum_out, flag_out and ovf_out update only on the completion edge and hold otherwise.

## Timing
- Reset values: busy_out = 0, done_out = 0, sum_out = 0, flag_out = 0, ovf_out = 0. State = IDLE, counter = 0.
- Start accepted on edge t0. busy_out is high from t0 up to edge tN.
- Digits are computed on edges t1..tN.
- After edge tN:
  - done_out = 1 for exactly one cycle;
  - results are valid;
  - busy_out = 0.
- Latency from the start edge to done_out high is N cycles: 8 for WIDTH=8/DIGIT=1, 2 for WIDTH=8/DIGIT=4.
- Back-to-back operation: start_in high during the done_out cycle is accepted on edge tN+1. Maximum throughput is one operation per N+1 cycles.
- Reset asserted mid-operation:
  - immediately returns all outputs and state to reset values;
  - the operation is discarded and no done_out is issued;
  - the first start after deassertion behaves normally.
- Counter wrap: the counter returns to 0 on completion; it never counts past N−1.

## Configuration
- ADD_SUB_SAT_EN defined: on signed overflow, sum_out saturates.
  - To 2^(WIDTH−1)−1 when signA = 0.
  - To −2^(WIDTH−1) when signA = 1.
  - ovf_out and flag_out are still reported unchanged.
- ADD_SUB_SAT_EN undefined: sum_out is always the wrapped modulo result.

## Test plan
- WIDTH=8, DIGIT=1, add 0x7F + 0x01 -> done_out 8 cycles after start; sum_out = 0x80, flag_out = 0, ovf_out = 1 (0x7F with ADD_SUB_SAT_EN).
- Subtract 0x05 − 0x07 -> sum_out = 0xFE, flag_out = 0 (borrow), ovf_out = 0. Subtract 0x80 − 0x01 -> sum_out = 0x7F, flag_out = 1, ovf_out = 1 (0x80 with ADD_SUB_SAT_EN).
- WIDTH=8, DIGIT=4, add 0xFF + 0x01 -> done_out 2 cycles after start; sum_out = 0x00, flag_out = 1, ovf_out = 0.
- start_in pulsed with different operands during busy -> ignored, original result delivered. start_in held high through done_out -> second operation accepted on the next edge, and exactly one done_out pulse occurs per operation.
- rst_n_in low for one cycle at digit 3 of 8 -> all outputs 0 immediately, no done_out. A new add 0x10 + 0x20 afterwards -> sum_out = 0x30 after 8 cycles.
- Random regression: 10k operand/opcode pairs for DIGIT ∈ {1, 2, 4, 8} -> sum_out, flag_out and ovf_out match a reference model, with and without ADD_SUB_SAT_EN.
